tty_char_fetch: RTL and testbench

//   FPGA-side reader of the HPS-written text RAM (ram1 port of the on-chip character buffer).
//   On each frame_start it sweeps the ROWS x COLS character grid in row-major order.

---
 rtl/tty_char_fetch.sv | 179 +++++++++++++++++
 tb/tb_tty_char_fetch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tty_char_fetch.sv
// Sweeps the on-chip character RAM once per frame in row-major order, applying a
// row scroll offset, and streams each character with its screen position downstream.
module tty_char_fetch #(
    parameter int COLS      = 40,
    parameter int ROWS      = 30,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 16
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              frame_start,
    input  logic [4:0]        scroll_row,
    output logic              busy,
    output logic [ADDR_W-1:0] ram1_address,
    output logic              ram1_chipselect,
    output logic              ram1_clken,
    output logic              ram1_write,
    output logic [7:0]        ram1_writedata,
    input  logic [7:0]        ram1_readdata,
    output logic              ch_valid,
    input  logic              ch_ready,
    output logic [7:0]        ch_code,
    output logic [5:0]        ch_col,
    output logic [4:0]        ch_row,
    output logic              ch_last
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic       last;
        logic [4:0] row;
        logic [5:0] col;
        logic [7:0] code;
    } entry_t;

    state_t     state, state_next;
    logic [5:0] col_q;
    logic [4:0] row_q;
    logic [4:0] scroll_q;

    logic       inflight;
    logic [5:0] inflight_col;
    logic [4:0] inflight_row;
    logic       inflight_last;

    entry_t     fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_count;

    logic       issue;
    logic       push;
    logic       pop;
    logic       at_end;
    logic [1:0] occ_after_pop;
    logic [5:0] row_sum;
    logic [5:0] rot_row;
    logic [ADDR_W-1:0] issue_addr;
    entry_t     head;

    assign ch_valid = (fifo_count != 2'd0);
    assign pop      = ch_valid & ch_ready;
    assign push     = inflight;
    assign at_end   = (col_q == 6'(COLS - 1)) && (row_q == 5'(ROWS - 1));

    // The slot freed by this cycle's pop can be refilled by a new issue, which keeps
    // one character per cycle flowing while never exceeding two outstanding entries.
    assign occ_after_pop = fifo_count - 2'(pop) + 2'(inflight);

    assign row_sum    = {1'b0, row_q} + {1'b0, scroll_q};
    assign rot_row    = (row_sum >= 6'(ROWS)) ? row_sum - 6'(ROWS) : row_sum;
    assign issue_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(rot_row) * ADDR_W'(COLS) + ADDR_W'(col_q);

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (frame_start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (occ_after_pop < 2'd2) begin
                    issue = 1'b1;
                    if (at_end) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!inflight && (fifo_count - 2'(pop)) == 2'd0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state    <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            scroll_q <= '0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && frame_start) begin
                scroll_q <= (32'(scroll_row) >= ROWS) ? 5'd0 : scroll_row;
                col_q    <= '0;
                row_q    <= '0;
            end else if (issue) begin
                if (col_q == 6'(COLS - 1)) begin
                    col_q <= '0;
                    row_q <= row_q + 5'd1;
                end else begin
                    col_q <= col_q + 6'd1;
                end
            end
        end
    end

    // Position tags travel alongside the RAM read so they meet the data one cycle later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            inflight      <= 1'b0;
            inflight_col  <= '0;
            inflight_row  <= '0;
            inflight_last <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_col  <= col_q;
                inflight_row  <= row_q;
                inflight_last <= at_end;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{last: inflight_last, row: inflight_row,
                                      col: inflight_col, code: ram1_readdata};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(push) - 2'(pop);
        end
    end

    assign head = fifo_mem[rd_ptr];

    assign busy            = (state != ST_IDLE);
    assign ram1_chipselect = issue;
    assign ram1_clken      = issue;
    assign ram1_address    = issue ? issue_addr : '0;
    assign ram1_write      = 1'b0;
    assign ram1_writedata  = 8'd0;

    assign ch_code = ch_valid ? head.code : 8'd0;
    assign ch_col  = ch_valid ? head.col  : 6'd0;
    assign ch_row  = ch_valid ? head.row  : 5'd0;
    assign ch_last = ch_valid ? head.last : 1'b0;

endmodule

// File: tb/tb_tty_char_fetch.sv
// Scoreboard bench for tty_char_fetch: a RAM model answers reads, a reference model
// queues expected addresses and characters per sweep, and a monitor checks them.
module tb_tty_char_fetch;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int NCHAR = COLS * ROWS;

    typedef struct packed {
        logic       last;
        logic [4:0] row;
        logic [5:0] col;
        logic [7:0] code;
    } exp_t;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [4:0]  scroll_row = '0;
    logic        busy;
    logic [15:0] ram1_address;
    logic        ram1_chipselect;
    logic        ram1_clken;
    logic        ram1_write;
    logic [7:0]  ram1_writedata;
    logic [7:0]  ram1_readdata = '0;
    logic        ch_valid;
    logic        ch_ready = 1'b0;
    logic [7:0]  ch_code;
    logic [5:0]  ch_col;
    logic [4:0]  ch_row;
    logic        ch_last;

    logic [7:0]  ram_mem [65536];

    int   total = 0;
    int   bad   = 0;
    int   issued, accepted, max_occ;
    logic write_seen;
    logic stalled_prev = 1'b0;
    exp_t prev_fields;
    int   exp_addr_q [$];
    exp_t exp_ch_q [$];
    int   obs_addr [$];
    exp_t obs_ch [$];

    tty_char_fetch #(.COLS(COLS), .ROWS(ROWS), .BASE_ADDR(0), .ADDR_W(16)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .frame_start(frame_start),
        .scroll_row(scroll_row), .busy(busy), .ram1_address(ram1_address),
        .ram1_chipselect(ram1_chipselect), .ram1_clken(ram1_clken), .ram1_write(ram1_write),
        .ram1_writedata(ram1_writedata), .ram1_readdata(ram1_readdata), .ch_valid(ch_valid),
        .ch_ready(ch_ready), .ch_code(ch_code), .ch_col(ch_col), .ch_row(ch_row),
        .ch_last(ch_last)
    );

    always #5 clk_clk = ~clk_clk;

    // Synchronous-read RAM: data appears the cycle after the read is issued.
    always @(posedge clk_clk) begin
        if (ram1_chipselect && ram1_clken) ram1_readdata <= ram_mem[ram1_address];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: screen (r,c) shows RAM word ((r+scroll) mod ROWS)*COLS + c.
    task automatic push_model(input logic [4:0] scroll);
        int s;
        int a;
        exp_t e;
        s = (scroll >= ROWS) ? 0 : int'(scroll);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                a = ((r + s) % ROWS) * COLS + c;
                exp_addr_q.push_back(a);
                e.last = (r == ROWS - 1) && (c == COLS - 1);
                e.row  = 5'(r);
                e.col  = 6'(c);
                e.code = ram_mem[a];
                exp_ch_q.push_back(e);
            end
        end
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset_n) begin
            stalled_prev = 1'b0;
        end else begin
            if (issued - accepted > max_occ) max_occ = issued - accepted;
            if (ram1_write !== 1'b0 || ram1_writedata !== 8'd0) write_seen = 1'b1;
            if (ram1_chipselect) begin
                check_output("addr_expected", 32'(exp_addr_q.size() != 0), 1);
                if (exp_addr_q.size() != 0) check_output("ram1_address", 32'(ram1_address), 32'(exp_addr_q.pop_front()));
                check_output("ram1_clken", 32'(ram1_clken), 1);
                obs_addr.push_back(int'(ram1_address));
                issued++;
            end
            if (stalled_prev) begin
                check_output("stall_hold", {12'd0, ch_valid, ch_last, ch_row, ch_col, ch_code},
                             {12'd0, 1'b1, prev_fields});
            end
            if (ch_valid && ch_ready) begin
                check_output("char_expected", 32'(exp_ch_q.size() != 0), 1);
                if (exp_ch_q.size() != 0) begin
                    check_output("char_fields", {12'd0, ch_last, ch_row, ch_col, ch_code},
                                 {12'd0, exp_ch_q.pop_front()});
                end
                obs_ch.push_back({ch_last, ch_row, ch_col, ch_code});
                accepted++;
            end
            stalled_prev = ch_valid && !ch_ready;
            prev_fields  = {ch_last, ch_row, ch_col, ch_code};
        end
    end

    task automatic check_reset_outputs();
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_ch_valid", 32'(ch_valid), 0);
        check_output("rst_ch_last", 32'(ch_last), 0);
        check_output("rst_chipselect", 32'(ram1_chipselect), 0);
        check_output("rst_clken", 32'(ram1_clken), 0);
        check_output("rst_address", 32'(ram1_address), 0);
        check_output("rst_fields", {13'd0, ch_code, ch_col, ch_row}, 0);
    endtask

    // One sweep; optionally injects a second frame_start or aborts with reset at a char count.
    task automatic apply_stimulus(input logic [4:0] scroll, input int ready_pct, input int inject_cycle,
                                  input int abort_char, output int first_valid, output int done_cycle);
        int cycle;
        issued = 0; accepted = 0; max_occ = 0; write_seen = 1'b0;
        obs_addr.delete(); obs_ch.delete();
        push_model(scroll);
        @(posedge clk_clk); #1;
        scroll_row  = scroll;
        frame_start = 1'b1;
        ch_ready    = ($urandom_range(0, 99) < ready_pct);
        first_valid = -1;
        done_cycle  = -1;
        cycle       = 0;
        while (cycle < 20000) begin
            @(posedge clk_clk); #1;
            cycle++;
            frame_start = (cycle == inject_cycle);
            scroll_row  = 5'($urandom);
            ch_ready    = ($urandom_range(0, 99) < ready_pct);
            if (abort_char >= 0 && accepted >= abort_char) begin
                reset_reset_n = 1'b0;
                #1;
                check_reset_outputs();
                exp_addr_q.delete();
                exp_ch_q.delete();
                done_cycle = cycle;
                @(posedge clk_clk); #1;
                reset_reset_n = 1'b1;
                break;
            end
            @(negedge clk_clk);
            if (first_valid < 0 && ch_valid) first_valid = cycle;
            if (!busy) begin
                done_cycle = cycle;
                break;
            end
        end
        frame_start = 1'b0;
        check_output("sweep_terminated", 32'(busy), 0);
    endtask

    task automatic check_sweep_end(input string tag);
        check_output({tag, "_count"}, 32'(accepted), NCHAR);
        check_output({tag, "_addr_q_empty"}, 32'(exp_addr_q.size()), 0);
        check_output({tag, "_ch_q_empty"}, 32'(exp_ch_q.size()), 0);
        check_output({tag, "_occ_le_2"}, 32'(max_occ <= 2), 1);
        check_output({tag, "_no_write"}, 32'(write_seen), 0);
    endtask

    initial begin
        int fv, dc;
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'($urandom);

        #1;
        check_reset_outputs();
        repeat (3) @(posedge clk_clk);
        #1 reset_reset_n = 1'b1;

        $display("[TB] sweep, scroll 0, ready high");
        apply_stimulus(5'd0, 100, -1, -1, fv, dc);
        check_sweep_end("t1");
        check_output("t1_first_valid", 32'(fv), 3);
        check_output("t1_done_cycle", 32'(dc), 1203);
        check_output("t1_addr0", 32'(obs_addr[0]), 0);
        check_output("t1_addr_last", 32'(obs_addr[NCHAR-1]), 1199);

        $display("[TB] sweep, scroll 29");
        apply_stimulus(5'd29, 100, -1, -1, fv, dc);
        check_sweep_end("t2");
        check_output("t2_first_addr", 32'(obs_addr[0]), 1160);
        check_output("t2_first_row", 32'(obs_ch[0].row), 0);
        check_output("t2_char41_addr", 32'(obs_addr[40]), 0);
        check_output("t2_char41_row", 32'(obs_ch[40].row), 1);
        check_output("t2_last_addr", 32'(obs_addr[NCHAR-1]), 1159);

        $display("[TB] sweep, random ready");
        apply_stimulus(5'd0, 30, -1, -1, fv, dc);
        check_sweep_end("t3");

        $display("[TB] frame_start while busy");
        apply_stimulus(5'd0, 100, 500, -1, fv, dc);
        check_sweep_end("t4");
        check_output("t4_done_cycle", 32'(dc), 1203);
        apply_stimulus(5'd7, 100, -1, -1, fv, dc);
        check_sweep_end("t4b");
        check_output("t4b_first_addr", 32'(obs_addr[0]), 280);

        $display("[TB] reset mid-sweep");
        apply_stimulus(5'd3, 100, -1, 300, fv, dc);
        check_output("t5_aborted_at", 32'(accepted), 300);
        apply_stimulus(5'd0, 60, -1, -1, fv, dc);
        check_sweep_end("t5");
        check_output("t5_restart_addr", 32'(obs_addr[0]), 0);
        check_output("t5_restart_pos", {20'd0, obs_ch[0].row, obs_ch[0].col}, 0);

        $display("[TB] scroll 31 treated as 0");
        apply_stimulus(5'd31, 100, -1, -1, fv, dc);
        check_sweep_end("t6");
        check_output("t6_first_addr", 32'(obs_addr[0]), 0);
        check_output("t6_done_cycle", 32'(dc), 1203);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
